// File: rtl/neuron_mem_arb_pkg.sv
// Shared definitions for the neuron memory arbiter: FSM state encoding,
// default parameter values and a small width helper used by the arbiter.
package neuron_mem_pkg;

    localparam int NUM_WR_DEF = 20;
    localparam int NUM_RD_DEF = 2;
    localparam int DATA_W_DEF = 12;
    localparam int DEPTH_DEF  = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Width of an index into n items; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_mem_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr,
// wrapping from N-1 back to 0. Pure combinational, one-hot output.
module rr_arbiter
    import neuron_mem_pkg::*;
#(
    parameter  int N     = 4,
    localparam int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [2*N-1:0] req_dbl_s;
    logic [2*N-1:0] req_shr_s;
    logic [N-1:0]   rot_req_s;
    logic [N-1:0]   rot_pick_s;
    logic [2*N-1:0] gnt_dbl_s;

    // Rotate requests so ptr sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        req_dbl_s  = {req, req};
        req_shr_s  = req_dbl_s >> ptr;
        rot_req_s  = req_shr_s[N-1:0];
        rot_pick_s = rot_req_s & (~rot_req_s + N'(1));
        gnt_dbl_s  = {rot_pick_s, rot_pick_s} << ptr;
        gnt        = gnt_dbl_s[2*N-1:N];
    end

endmodule

// File: rtl/neuron_mem_arb.sv
// Neuron state memory with many write channels sharing one write port
// through a round-robin arbiter, independent latency-1 read ports and a
// full-memory clear sweep.
// Build option: define NEURON_MEM_FWD_EN to make a read that hits the
// address written on the same edge return the new data (write-first);
// by default such a read returns the old data (read-first).
module neuron_mem_arb
    import neuron_mem_pkg::*;
#(
    parameter  int NUM_WR = NUM_WR_DEF,
    parameter  int NUM_RD = NUM_RD_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_valid,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [NUM_WR-1:0]        wr_ready,
    input  logic                     clr_start,
    output logic                     busy,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data
);

    localparam int                PTR_W     = ptr_width(NUM_WR);
    // One extra bit so out-of-range checks never compare against a wrapped value.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  LAST_CH   = PTR_W'(NUM_WR - 1);

    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic                       busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;

    logic [DATA_W-1:0]          mem_q [DEPTH];

    logic [NUM_WR-1:0]          arb_gnt_s;
    logic                       grant_en_s;
    logic [NUM_WR-1:0]          wr_ready_s;
    logic [PTR_W-1:0]           gnt_idx_s;
    logic [PTR_W-1:0]           ptr_next_s;
    logic [ADDR_W-1:0]          gnt_addr_s;
    logic [DATA_W-1:0]          gnt_data_s;

    logic                       mem_we_s;
    logic [ADDR_W-1:0]          mem_waddr_s;
    logic [DATA_W-1:0]          mem_wdata_s;

    rr_arbiter #(
        .N (NUM_WR)
    ) u_rr_arbiter (
        .req (wr_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt_s)
    );

    // Grants are only offered in IDLE when no clear is starting and no reset is applied.
    always_comb begin
        grant_en_s = (state_q == IDLE) && !clr_start && !rst;
        wr_ready_s = grant_en_s ? arb_gnt_s : {NUM_WR{1'b0}};
    end

    // One-hot mux of the granted channel's index, address and data.
    always_comb begin
        gnt_idx_s  = {PTR_W{1'b0}};
        gnt_addr_s = {ADDR_W{1'b0}};
        gnt_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_WR; i++) begin
            gnt_idx_s  = gnt_idx_s  | ({PTR_W{wr_ready_s[i]}} & PTR_W'(i));
            gnt_addr_s = gnt_addr_s | ({ADDR_W{wr_ready_s[i]}} & wr_addr[i*ADDR_W +: ADDR_W]);
            gnt_data_s = gnt_data_s | ({DATA_W{wr_ready_s[i]}} & wr_data[i*DATA_W +: DATA_W]);
        end
        ptr_next_s = (gnt_idx_s == LAST_CH) ? {PTR_W{1'b0}} : (gnt_idx_s + PTR_W'(1));
    end

    // FSM next state, clear counter, round-robin pointer and the single write port.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ptr_d       = ptr_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if (rst) begin
            state_d   = IDLE;
            clr_cnt_d = {ADDR_W{1'b0}};
            ptr_d     = {PTR_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        state_d   = CLEAR;
                        clr_cnt_d = {ADDR_W{1'b0}};
                    end else if (|wr_ready_s) begin
                        ptr_d = ptr_next_s;
                        // Out-of-range addresses are accepted but never stored.
                        if ({1'b0, gnt_addr_s} < DEPTH_X) begin
                            mem_we_s    = 1'b1;
                            mem_waddr_s = gnt_addr_s;
                            mem_wdata_s = gnt_data_s;
                        end else begin
                            mem_we_s    = 1'b0;
                        end
                    end else begin
                        ptr_d = ptr_q;
                    end
                end
                CLEAR: begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = clr_cnt_q;
                    mem_wdata_s = {DATA_W{1'b0}};
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d   = IDLE;
                        clr_cnt_d = {ADDR_W{1'b0}};
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    clr_cnt_d = {ADDR_W{1'b0}};
                end
            endcase
        end
        busy_d = (state_d == CLEAR);
    end

    // Per-port read data for the next cycle; out-of-range reads return zero.
    always_comb begin
        rd_data_d = {(NUM_RD*DATA_W){1'b0}};
        for (int p = 0; p < NUM_RD; p++) begin
            if (rst) begin
                rd_data_d[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if ({1'b0, rd_addr[p*ADDR_W +: ADDR_W]} >= DEPTH_X) begin
                rd_data_d[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
`ifdef NEURON_MEM_FWD_EN
            end else if (mem_we_s && (mem_waddr_s == rd_addr[p*ADDR_W +: ADDR_W])) begin
                rd_data_d[p*DATA_W +: DATA_W] = mem_wdata_s;
`endif
            end else begin
                rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_addr[p*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_cnt_q <= {ADDR_W{1'b0}};
            ptr_q     <= {PTR_W{1'b0}};
            busy_q    <= 1'b0;
            rd_data_q <= {(NUM_RD*DATA_W){1'b0}};
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign wr_ready = wr_ready_s;
    assign busy     = busy_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_neuron_mem_arb.sv
// Self-checking bench for neuron_mem_arb: vector table for single writes,
// scoreboard for read data, hand sequences for arbitration, clear and reset.
module tb_neuron_mem_arb;
    import neuron_mem_pkg::*;

    localparam int NW = 20;
    localparam int NR = 2;
    localparam int DW = 12;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int D2 = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, clr_start, busy;
    logic [NW-1:0]    wr_valid, wr_ready;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;

    logic           rst2, clr2, busy2;
    logic [NW-1:0]    wv2, rdy2;
    logic [NW*AW-1:0] wa2;
    logic [NW*DW-1:0] wd2;
    logic [NR*AW-1:0] rd2;
    logic [NR*DW-1:0] rdd2;

    neuron_mem_arb #(.NUM_WR(NW), .NUM_RD(NR), .DATA_W(DW), .DEPTH(D)) u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .clr_start(clr_start), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    neuron_mem_arb #(.NUM_WR(NW), .NUM_RD(NR), .DATA_W(DW), .DEPTH(D2)) u_dut24 (
        .clk(clk), .rst(rst2), .wr_valid(wv2), .wr_addr(wa2), .wr_data(wd2),
        .wr_ready(rdy2), .clr_start(clr2), .busy(busy2), .rd_addr(rd2), .rd_data(rdd2)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            port;
        logic [DW-1:0] d;
        string         nm;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int            ch;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NW-1:0] exp_rdy;
    } vec_t;
    vec_t vecs [5];

    logic [DW-1:0] mdl [D];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [NW-1:0] oh(input int k);
        logic [NW-1:0] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    task automatic set_ch(input int ch, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid[ch]          = v;
        wr_addr[ch*AW +: AW]  = a;
        wr_data[ch*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    // One clock cycle: check grant/busy, push read expectations, update model, pop after edge.
    task automatic step(input logic [NW-1:0] exp_rdy, input logic exp_busy, input int clr_wa,
                        input bit chk_rd, input string nm);
        int            g;
        bit            we;
        logic [AW-1:0] wa, a;
        logic [DW-1:0] wd, e;
        exp_t          it;
        @(negedge clk);
        chk({nm, "_rdy"}, 64'(wr_ready), 64'(exp_rdy));
        chk({nm, "_busy"}, 64'(busy), 64'(exp_busy));
        we = 1'b0; wa = '0; wd = '0; g = -1;
        for (int i = 0; i < NW; i++) if (exp_rdy[i]) g = i;
        if (!rst) begin
            if (clr_wa >= 0) begin
                we = 1'b1; wa = AW'(clr_wa); wd = '0;
            end else if (g >= 0) begin
                we = 1'b1; wa = wr_addr[g*AW +: AW]; wd = wr_data[g*DW +: DW];
            end
        end
        if (chk_rd) begin
            for (int p = 0; p < NR; p++) begin
                a = rd_addr[p*AW +: AW];
                e = rst ? '0 : mdl[a];
`ifdef NEURON_MEM_FWD_EN
                if (!rst && we && wa == a) e = wd;
`endif
                it.port = p; it.d = e; it.nm = {nm, "_rd"};
                sbq.push_back(it);
            end
        end
        if (we) mdl[wa] = wd;
        @(posedge clk); #1;
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            chk(it.nm, 64'(rd_data[it.port*DW +: DW]), 64'(it.d));
        end
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step('0, 1'b0, -1, 1'b1, "rst");
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; clr_start = 1'b0; wr_valid = '1; wr_addr = '0; wr_data = '0; rd_addr = '0;
        rst2 = 1'b1; clr2 = 1'b0; wv2 = '0; wa2 = '0; wd2 = '0; rd2 = '0;

        // Reset with every channel requesting
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rd", 64'(rd_data), 64'(0));
        chk("rst_rdy", 64'(wr_ready), 64'(0));
        wr_valid = '0;
        rst = 1'b0;

        // Clear sweep with ch0 waiting and a stray clr_start mid-sweep
        set_ch(0, 1'b1, 5'd0, 12'h3C3);
        clr_start = 1'b1;
        step('0, 1'b0, -1, 1'b0, "clr_start");
        for (int c = 0; c < D; c++) begin
            clr_start = (c == 5) ? 1'b1 : 1'b0;
            step('0, 1'b1, c, 1'b0, "clr_sweep");
        end
        clr_start = 1'b0;
        step(oh(0), 1'b0, -1, 1'b0, "clr_after");
        set_ch(0, 1'b0, 5'd0, 12'h3C3);
        for (int a = 0; a < D/2; a++) begin
            set_rd(2*a, 2*a+1);
            step('0, 1'b0, -1, 1'b1, "clr_words");
        end

        // Reset beats clr_start and a pending write
        rst = 1'b1; clr_start = 1'b1;
        set_ch(1, 1'b1, 5'd3, 12'h555);
        set_rd(3, 3);
        step('0, 1'b0, -1, 1'b1, "rst_ovr");
        rst = 1'b0; clr_start = 1'b0;
        set_ch(1, 1'b0, 5'd3, 12'h555);
        step('0, 1'b0, -1, 1'b1, "rst_ovr_after");

        // Vector table: single-channel writes and read-back
        vecs[0] = '{3,  5'd5,  12'hABC, oh(3)};
        vecs[1] = '{0,  5'd0,  12'h001, oh(0)};
        vecs[2] = '{19, 5'd31, 12'hFFF, oh(19)};
        vecs[3] = '{10, 5'd16, 12'h5A5, oh(10)};
        vecs[4] = '{7,  5'd5,  12'h321, oh(7)};
        for (int i = 0; i < 5; i++) begin
            set_ch(vecs[i].ch, 1'b1, vecs[i].addr, vecs[i].data);
            step(vecs[i].exp_rdy, 1'b0, -1, 1'b0, "vec_wr");
            set_ch(vecs[i].ch, 1'b0, vecs[i].addr, vecs[i].data);
            set_rd(int'(vecs[i].addr), 31 - int'(vecs[i].addr));
            step('0, 1'b0, -1, 1'b1, "vec");
        end

        // Round-robin: pointer advance, hold on idle, wrap
        do_rst();
        set_ch(2, 1'b1, 5'd20, 12'h202);
        set_ch(7, 1'b1, 5'd21, 12'h707);
        step(oh(2), 1'b0, -1, 1'b0, "rr_a");
        set_ch(2, 1'b0, 5'd20, 12'h202);
        step(oh(7), 1'b0, -1, 1'b0, "rr_b");
        set_ch(7, 1'b0, 5'd21, 12'h707);
        set_ch(3, 1'b1, 5'd22, 12'h303);
        set_ch(15, 1'b1, 5'd23, 12'hF0F);
        step(oh(15), 1'b0, -1, 1'b0, "rr_c");
        set_ch(15, 1'b0, 5'd23, 12'hF0F);
        set_ch(3, 1'b0, 5'd22, 12'h303);
        step('0, 1'b0, -1, 1'b0, "rr_idle");
        set_ch(3, 1'b1, 5'd22, 12'h303);
        set_ch(19, 1'b1, 5'd24, 12'h919);
        step(oh(19), 1'b0, -1, 1'b0, "rr_d");
        set_ch(19, 1'b0, 5'd24, 12'h919);
        step(oh(3), 1'b0, -1, 1'b0, "rr_e");
        set_ch(3, 1'b0, 5'd22, 12'h303);
        set_rd(20, 21);
        step('0, 1'b0, -1, 1'b1, "rr_rd1");
        set_rd(22, 24);
        step('0, 1'b0, -1, 1'b1, "rr_rd2");

        // All channels requesting continuously from ptr 0
        do_rst();
        for (int i = 0; i < NW; i++) set_ch(i, 1'b1, AW'(i), 12'(12'h100 + i));
        for (int k = 0; k <= NW; k++) step(oh(k % NW), 1'b0, -1, 1'b0, "rr_all");
        wr_valid = '0;
        for (int a = 0; a < NW/2; a++) begin
            set_rd(2*a, 2*a+1);
            step('0, 1'b0, -1, 1'b1, "rr_all_rd");
        end

        // Same-edge read/write collision on address 7
        set_ch(5, 1'b1, 5'd7, 12'h123);
        set_rd(7, 7);
        step(oh(5), 1'b0, -1, 1'b1, "collide");
        set_ch(5, 1'b0, 5'd7, 12'h123);
        step('0, 1'b0, -1, 1'b1, "collide_after");

        // Fill, start clear, reset at clear cycle 10
        for (int a = 0; a < D; a++) begin
            set_ch(a % NW, 1'b1, AW'(a), 12'(12'h800 + a));
            step(oh(a % NW), 1'b0, -1, 1'b0, "fill");
            set_ch(a % NW, 1'b0, AW'(a), 12'(12'h800 + a));
        end
        clr_start = 1'b1;
        step('0, 1'b0, -1, 1'b0, "clr2_start");
        clr_start = 1'b0;
        for (int c = 0; c < 10; c++) step('0, 1'b1, c, 1'b0, "clr2_sweep");
        rst = 1'b1;
        set_rd(0, 31);
        step('0, 1'b1, -1, 1'b1, "rst_mid");
        rst = 1'b0;
        for (int a = 0; a < D/2; a++) begin
            set_rd(2*a, 2*a+1);
            step('0, 1'b0, -1, 1'b1, "rst_mid_rd");
        end

        // DEPTH=24 instance: out-of-range write and read
        rst2 = 1'b0;
        clr2 = 1'b1;
        @(posedge clk); #1;
        clr2 = 1'b0;
        n = 0;
        while (busy2 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("d24_busy_len", 64'(n), 64'(D2));
        wv2[0] = 1'b1; wa2[0 +: AW] = 5'd30; wd2[0 +: DW] = 12'hFFF;
        @(negedge clk);
        chk("d24_rdy", 64'(rdy2), 64'(oh(0)));
        @(posedge clk); #1;
        wv2 = '0;
        for (int a = 0; a < D2; a++) begin
            rd2 = {5'd30, AW'(a)};
            @(posedge clk); #1;
            chk("d24_word", 64'(rdd2[0 +: DW]), 64'(0));
            chk("d24_rd30", 64'(rdd2[DW +: DW]), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_mem_arb.md
NEURON_MEM_ARB -- requirements
Module: neuron_mem_arb

Interface
REQ-001 Parameter NUM_WR, default 20: number of write channels.
REQ-002 Parameter NUM_RD, default 2: number of read ports.
REQ-003 Parameter DATA_W, default 12: word width in bits.
REQ-004 Parameter DEPTH, default 32: number of words; ADDR_W = clog2(DEPTH), derived, not overridable.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 wr_valid  in  NUM_WR  per-channel write request.
REQ-008 wr_addr  in  NUM_WR*ADDR_W  per-channel write address, channel i at slice i.
REQ-009 wr_data  in  NUM_WR*DATA_W  per-channel write data, channel i at slice i.
REQ-010 wr_ready  out  NUM_WR  one-hot grant; a write on channel i completes on the edge where wr_valid[i] and wr_ready[i] are both high.
REQ-011 clr_start  in  1  one-cycle pulse starting a full-memory clear sweep.
REQ-012 busy  out  1  high while the clear sweep runs.
REQ-013 rd_addr  in  NUM_RD*ADDR_W  per-port read address.
REQ-014 rd_data  out  NUM_RD*DATA_W  per-port registered read data.

Function
REQ-015 At most one write commits per cycle; wr_ready is combinational from wr_valid, round-robin pointer and FSM state.
REQ-016 Arbitration is round-robin: search starts at pointer ptr, wraps NUM_WR-1 -> 0; first valid channel is granted.
REQ-017 After a grant to channel g, ptr becomes (g+1) mod NUM_WR; with no grant, ptr holds.
REQ-018 Ungranted channels hold wr_valid, wr_addr, wr_data stable until granted; no write is ever dropped or redirected.
REQ-019 Write addresses >= DEPTH (non-power-of-two DEPTH) are granted and discarded; memory is unchanged.
REQ-020 FSM states IDLE and CLEAR; IDLE -> CLEAR on clr_start; CLEAR -> IDLE after the write to address DEPTH-1.
REQ-021 In CLEAR, one word per cycle is zeroed, address counter 0..DEPTH-1, DEPTH cycles total; busy high for exactly those DEPTH cycles.
REQ-022 In CLEAR and in the cycle clr_start is sampled, wr_ready is all-zero and ptr holds.
REQ-023 clr_start while in CLEAR is ignored; the sweep does not restart.
REQ-024 Each read port returns mem[rd_addr] on rd_data one cycle after rd_addr is sampled (latency 1); ports are independent and may address the same word.
REQ-025 Read addresses >= DEPTH return zero.
REQ-026 Reads remain enabled during CLEAR and follow the same collision rule as user writes (REQ-033).

Reset
REQ-027 On rst: FSM IDLE, ptr 0, clear counter 0, busy 0, rd_data all zero, wr_ready all zero in that cycle.
REQ-028 rst overrides clr_start and any wr_valid in the same cycle; no write commits.
REQ-029 rst during CLEAR aborts the sweep; words already zeroed stay zero, remaining words retain prior contents.
REQ-030 Memory array contents are not reset.

Configuration
REQ-031 Macro NEURON_MEM_FWD_EN selects read/write collision behaviour.
REQ-032 Defined: a read whose address equals the address written on the same edge returns the new data (write-first).
REQ-033 Undefined: such a read returns the old data (read-first); no forwarding logic is present.

Structure
REQ-034 Package neuron_mem_pkg holds the FSM state enum (IDLE, CLEAR) and default values of NUM_WR, NUM_RD, DATA_W, DEPTH.
REQ-035 Round-robin selection is a sub-module rr_arbiter (parameter N; inputs req, ptr; output one-hot gnt).

Verification
REQ-036 Defaults; ch3 valid addr 5 data 0xABC alone -> wr_ready[3] high that cycle; rd_addr 5 two cycles later -> rd_data 0xABC.
REQ-037 All 20 channels valid continuously, ptr=0 -> grants ch0,1,...,19,0 in consecutive cycles; each channel's data lands at its address.
REQ-038 clr_start with ch0 valid -> no grant that cycle; busy high 32 cycles; all words read 0x000; ch0 granted in first cycle after busy falls.
REQ-039 Write 0x123 to addr 7 while both ports read addr 7 -> next-cycle rd_data 0x123 with NEURON_MEM_FWD_EN, previous value without.
REQ-040 rst asserted at clear cycle 10 -> busy 0, rd_data 0 next cycle; addr 0..9 read 0, addr 10..31 keep prior values.
REQ-041 DEPTH=24: write addr 30 granted, no word changes; read addr 30 returns 0.
